rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Consumer at the commit end of the reorder buffer (ROB).
- Pops the ROB head when it is ready and retires it to the architectural register file.
- When the head carries an exception, it raises a pipeline-wide flush, reports the exception to CP0, and blocks further commits for a fixed drain window.
- Sits between the ROB commit port and the register file / CP0.

Parameters:
- DATA_WIDTH, 32, register data and PC width.
- REG_ADDR_WIDTH, 5, architectural register index width.
- EXC_TYPE_WIDTH, 4, exception code width; code 0 means no exception.
- DRAIN_CYCLES, 3, cycles spent in DRAIN after a flush; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous active-low reset.
- can_commit_in  in  1  ROB head is valid and completed.
- commit_reg_write_en_in  in  1  head instruction writes a register.
- commit_reg_write_addr_in  in  REG_ADDR_WIDTH  head destination register.
- commit_reg_write_data_in  in  DATA_WIDTH  head result.
- commit_exception_type_in  in  EXC_TYPE_WIDTH  head exception code.
- commit_is_delayslot_in  in  1  head is in a branch delay slot.
- commit_pc_in  in  DATA_WIDTH  head PC.
- commit_stall_in  in  1  external backpressure; blocks new commits.
- commit_en_out  out  1  combinational pop strobe to the ROB.
- rf_write_en_out  out  1  register-file write enable (registered).
- rf_write_addr_out  out  REG_ADDR_WIDTH  register-file write address.
- rf_write_data_out  out  DATA_WIDTH  register-file write data.
- flush_out  out  1  one-cycle pipeline and ROB erase-all pulse.
- exc_valid_out  out  1  one-cycle exception report to CP0.
- exc_type_out  out  EXC_TYPE_WIDTH  reported exception code.
- exc_epc_out  out  DATA_WIDTH  exception PC (EPC).
- exc_is_delayslot_out  out  1  reported delay-slot flag.
- busy_out  out  1  high while in the FLUSH or DRAIN state.
- retired_count_out  out  32  count of instructions popped in IDLE, including excepting ones.

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE.
  - All registered outputs clear to 0; retired_count_out = 0; drain counter = 0.
  - commit_en_out = 0 while rst is low.
- States: IDLE, FLUSH, DRAIN.
- commit_en_out = (state == IDLE) && can_commit_in && !commit_stall_in. It is purely combinational, and the ROB pops the head on the same posedge.
- IDLE, on a posedge with commit_en_out = 1 and exception code == 0:
  - rf_write_en_out <= commit_reg_write_en_in && (addr != 0); register $zero is never written.
  - rf_write_addr_out and rf_write_data_out <= the head's address and data. Latency is 1 cycle.
  - retired_count_out increments by 1 and wraps modulo 2^32.
- IDLE, on a posedge with commit_en_out = 1 and exception code != 0:
  - rf_write_en_out <= 0.
  - exc_valid_out <= 1; exc_type_out <= code; exc_is_delayslot_out <= the flag.
  - exc_epc_out <= is_delayslot ? pc - 4 : pc, computed modulo 2^DATA_WIDTH.
  - retired_count_out increments; next state is FLUSH.
- IDLE with no commit: rf_write_en_out <= 0; exc_valid_out <= 0.
- FLUSH (exactly 1 cycle):
  - flush_out = 1, registered: it is asserted in the cycle after the excepting pop.
  - exc_valid_out is high during this same cycle. rf_write_en_out = 0.
  - Drain counter loads DRAIN_CYCLES; next state is DRAIN.
- DRAIN:
  - flush_out = 0; exc_valid_out = 0. can_commit_in is ignored and commit_en_out = 0.
  - The counter decrements each cycle; when it reaches 1, next state is IDLE.
  - Total DRAIN length = DRAIN_CYCLES cycles.
- busy_out = (state != IDLE).
- commit_stall_in only gates commits in IDLE. It does not extend FLUSH or DRAIN.
- Exception fields (exc_type_out, exc_epc_out, exc_is_delayslot_out) hold their last value until the next exception.
- No simultaneous-event conflicts exist: at most one pop per cycle, and exception handling pre-empts all commits.
- Reset mid-FLUSH or mid-DRAIN: immediate return to IDLE with all outputs cleared. No flush_out glitch after rst deasserts.

Test Plan:
- Reset with can_commit_in = 1 -> commit_en_out = 0 and all outputs 0. After rst goes high, commit_en_out = 1 in the same cycle.
- Head {we=1, addr=8, data=0x1234, exc=0} -> next cycle rf_write_en_out = 1, addr = 8, data = 0x1234, retired_count_out = 1. A second head {we=1, addr=0} -> rf_write_en_out = 0 and retired_count_out = 2.
- commit_stall_in = 1 for 3 cycles with can_commit_in = 1 -> commit_en_out = 0 and the count is unchanged. Stall released -> commit resumes the next cycle.
- Head {exc=4, pc=0xbfc00010, ds=1} -> next cycle exc_valid_out = 1, flush_out = 1, exc_epc_out = 0xbfc0000c, busy_out = 1, rf_write_en_out = 0. Then 3 DRAIN cycles with commit_en_out = 0 despite can_commit_in = 1. The 5th cycle after the pop is back in IDLE.
- Same exception with ds=0, pc=0xbfc00000 -> exc_epc_out = 0xbfc00000.
- Assert rst during DRAIN -> IDLE immediately, busy_out = 0, retired_count_out = 0, flush_out never re-pulses.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Commit stage at the head of the reorder buffer: retires completed
// instructions to the register file and turns an excepting head into a
// one-cycle flush, a CP0 exception report and a fixed drain window.
module rob_commit_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int EXC_TYPE_WIDTH = 4,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      can_commit_in,
  input  logic                      commit_reg_write_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] commit_reg_write_addr_in,
  input  logic [DATA_WIDTH-1:0]     commit_reg_write_data_in,
  input  logic [EXC_TYPE_WIDTH-1:0] commit_exception_type_in,
  input  logic                      commit_is_delayslot_in,
  input  logic [DATA_WIDTH-1:0]     commit_pc_in,
  input  logic                      commit_stall_in,
  output logic                      commit_en_out,
  output logic                      rf_write_en_out,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr_out,
  output logic [DATA_WIDTH-1:0]     rf_write_data_out,
  output logic                      flush_out,
  output logic                      exc_valid_out,
  output logic [EXC_TYPE_WIDTH-1:0] exc_type_out,
  output logic [DATA_WIDTH-1:0]     exc_epc_out,
  output logic                      exc_is_delayslot_out,
  output logic                      busy_out,
  output logic [31:0]               retired_count_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] drain_cnt;
  logic       has_exc;

  // A delay-slot instruction reports the PC of its branch (pc - 4), wrapping.
  function automatic logic [DATA_WIDTH-1:0] calc_epc(input logic [DATA_WIDTH-1:0] pc,
                                                     input logic ds);
    calc_epc = ds ? (pc - DATA_WIDTH'(4)) : pc;
  endfunction

  assign has_exc = (commit_exception_type_in != '0);

  // Pop strobe goes back to the ROB in the same cycle; held low during reset.
  assign commit_en_out = rst && (state == IDLE) && can_commit_in && !commit_stall_in;

  assign busy_out = (state != IDLE);

  // Commit state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      drain_cnt            <= '0;
      rf_write_en_out      <= 1'b0;
      rf_write_addr_out    <= '0;
      rf_write_data_out    <= '0;
      flush_out            <= 1'b0;
      exc_valid_out        <= 1'b0;
      exc_type_out         <= '0;
      exc_epc_out          <= '0;
      exc_is_delayslot_out <= 1'b0;
      retired_count_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          flush_out <= 1'b0;
          if (commit_en_out) begin
            retired_count_out <= retired_count_out + 32'd1;
            if (!has_exc) begin
              // Writes to $zero are dropped here so the RF never sees them.
              rf_write_en_out   <= commit_reg_write_en_in && (commit_reg_write_addr_in != '0);
              rf_write_addr_out <= commit_reg_write_addr_in;
              rf_write_data_out <= commit_reg_write_data_in;
              exc_valid_out     <= 1'b0;
            end else begin
              rf_write_en_out      <= 1'b0;
              exc_valid_out        <= 1'b1;
              flush_out            <= 1'b1;
              exc_type_out         <= commit_exception_type_in;
              exc_is_delayslot_out <= commit_is_delayslot_in;
              exc_epc_out          <= calc_epc(commit_pc_in, commit_is_delayslot_in);
              state                <= FLUSH;
            end
          end else begin
            rf_write_en_out <= 1'b0;
            exc_valid_out   <= 1'b0;
          end
        end
        FLUSH: begin
          rf_write_en_out <= 1'b0;
          flush_out       <= 1'b0;
          exc_valid_out   <= 1'b0;
          drain_cnt       <= 4'(DRAIN_CYCLES);
          state           <= DRAIN;
        end
        DRAIN: begin
          rf_write_en_out <= 1'b0;
          flush_out       <= 1'b0;
          exc_valid_out   <= 1'b0;
          if (drain_cnt != '0) drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) state <= IDLE;
        end
        default: begin
          rf_write_en_out <= 1'b0;
          flush_out       <= 1'b0;
          exc_valid_out   <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: reset, normal retire, $zero drop,
// stall gating, exception flush/drain timing, EPC wrap, reset mid-drain.
module tb_rob_commit_unit;

  logic        clk;
  logic        rst;
  logic        can_commit_in;
  logic        commit_reg_write_en_in;
  logic [4:0]  commit_reg_write_addr_in;
  logic [31:0] commit_reg_write_data_in;
  logic [3:0]  commit_exception_type_in;
  logic        commit_is_delayslot_in;
  logic [31:0] commit_pc_in;
  logic        commit_stall_in;
  logic        commit_en_out;
  logic        rf_write_en_out;
  logic [4:0]  rf_write_addr_out;
  logic [31:0] rf_write_data_out;
  logic        flush_out;
  logic        exc_valid_out;
  logic [3:0]  exc_type_out;
  logic [31:0] exc_epc_out;
  logic        exc_is_delayslot_out;
  logic        busy_out;
  logic [31:0] retired_count_out;

  int errors = 0;
  int checks = 0;

  rob_commit_unit #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .EXC_TYPE_WIDTH(4), .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .can_commit_in(can_commit_in),
    .commit_reg_write_en_in(commit_reg_write_en_in),
    .commit_reg_write_addr_in(commit_reg_write_addr_in),
    .commit_reg_write_data_in(commit_reg_write_data_in),
    .commit_exception_type_in(commit_exception_type_in),
    .commit_is_delayslot_in(commit_is_delayslot_in),
    .commit_pc_in(commit_pc_in),
    .commit_stall_in(commit_stall_in),
    .commit_en_out(commit_en_out),
    .rf_write_en_out(rf_write_en_out),
    .rf_write_addr_out(rf_write_addr_out),
    .rf_write_data_out(rf_write_data_out),
    .flush_out(flush_out),
    .exc_valid_out(exc_valid_out),
    .exc_type_out(exc_type_out),
    .exc_epc_out(exc_epc_out),
    .exc_is_delayslot_out(exc_is_delayslot_out),
    .busy_out(busy_out),
    .retired_count_out(retired_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic we, input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] exc, input logic ds, input logic [31:0] pc);
    commit_reg_write_en_in   = we;
    commit_reg_write_addr_in = addr;
    commit_reg_write_data_in = data;
    commit_exception_type_in = exc;
    commit_is_delayslot_in   = ds;
    commit_pc_in             = pc;
  endtask

  initial begin
    rst             = 1'b0;
    can_commit_in   = 1'b1;
    commit_stall_in = 1'b0;
    set_head(1'b1, 5'd8, 32'h0000_1234, 4'd0, 1'b0, 32'h0000_0100);

    // Reset held with a ready head.
    tick(); tick();
    check("rst_commit_en", 32'(commit_en_out), 32'd0);
    check("rst_rf_we",     32'(rf_write_en_out), 32'd0);
    check("rst_flush",     32'(flush_out), 32'd0);
    check("rst_exc_valid", 32'(exc_valid_out), 32'd0);
    check("rst_busy",      32'(busy_out), 32'd0);
    check("rst_count",     retired_count_out, 32'd0);
    check("rst_epc",       exc_epc_out, 32'd0);

    // Release reset between edges: pop strobe appears immediately.
    rst = 1'b1;
    #1;
    check("rel_commit_en", 32'(commit_en_out), 32'd1);

    // Normal retire of r8.
    tick();
    check("w1_we",    32'(rf_write_en_out), 32'd1);
    check("w1_addr",  32'(rf_write_addr_out), 32'd8);
    check("w1_data",  rf_write_data_out, 32'h0000_1234);
    check("w1_count", retired_count_out, 32'd1);

    // Write to $zero is suppressed but still retires.
    set_head(1'b1, 5'd0, 32'h0000_0055, 4'd0, 1'b0, 32'h0000_0104);
    tick();
    check("w0_we",    32'(rf_write_en_out), 32'd0);
    check("w0_count", retired_count_out, 32'd2);

    // Stall for three cycles.
    commit_stall_in = 1'b1;
    set_head(1'b1, 5'd3, 32'h0000_0abc, 4'd0, 1'b0, 32'h0000_0108);
    #1;
    check("stall_commit_en", 32'(commit_en_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_count", retired_count_out, 32'd2);
      check("stall_we",    32'(rf_write_en_out), 32'd0);
    end
    commit_stall_in = 1'b0;
    #1;
    check("unstall_commit_en", 32'(commit_en_out), 32'd1);
    tick();
    check("unstall_we",    32'(rf_write_en_out), 32'd1);
    check("unstall_addr",  32'(rf_write_addr_out), 32'd3);
    check("unstall_data",  rf_write_data_out, 32'h0000_0abc);
    check("unstall_count", retired_count_out, 32'd3);

    // Exception in a delay slot.
    set_head(1'b1, 5'd5, 32'h0000_dead, 4'd4, 1'b1, 32'hbfc0_0010);
    tick();
    check("exc1_valid", 32'(exc_valid_out), 32'd1);
    check("exc1_flush", 32'(flush_out), 32'd1);
    check("exc1_epc",   exc_epc_out, 32'hbfc0_000c);
    check("exc1_type",  32'(exc_type_out), 32'd4);
    check("exc1_ds",    32'(exc_is_delayslot_out), 32'd1);
    check("exc1_busy",  32'(busy_out), 32'd1);
    check("exc1_we",    32'(rf_write_en_out), 32'd0);
    check("exc1_count", retired_count_out, 32'd4);
    check("flush_commit_en", 32'(commit_en_out), 32'd0);
    set_head(1'b1, 5'd7, 32'h0000_0077, 4'd0, 1'b0, 32'h0000_0180);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_flush",     32'(flush_out), 32'd0);
      check("drain_exc_valid", 32'(exc_valid_out), 32'd0);
      check("drain_busy",      32'(busy_out), 32'd1);
      check("drain_commit_en", 32'(commit_en_out), 32'd0);
      check("drain_count",     retired_count_out, 32'd4);
    end
    tick();
    check("post_busy",      32'(busy_out), 32'd0);
    check("post_commit_en", 32'(commit_en_out), 32'd1);
    tick();
    check("post_we",       32'(rf_write_en_out), 32'd1);
    check("post_addr",     32'(rf_write_addr_out), 32'd7);
    check("post_count",    retired_count_out, 32'd5);
    check("post_hold_epc", exc_epc_out, 32'hbfc0_000c);
    check("post_hold_typ", 32'(exc_type_out), 32'd4);

    // Exception outside a delay slot.
    set_head(1'b0, 5'd0, 32'h0, 4'd4, 1'b0, 32'hbfc0_0000);
    tick();
    check("exc2_valid", 32'(exc_valid_out), 32'd1);
    check("exc2_epc",   exc_epc_out, 32'hbfc0_0000);
    check("exc2_ds",    32'(exc_is_delayslot_out), 32'd0);
    check("exc2_count", retired_count_out, 32'd6);
    can_commit_in = 1'b0;
    tick();
    check("exc2_drain_busy", 32'(busy_out), 32'd1);

    // Asynchronous reset in the middle of DRAIN.
    rst = 1'b0;
    #1;
    check("rd_busy",      32'(busy_out), 32'd0);
    check("rd_count",     retired_count_out, 32'd0);
    check("rd_flush",     32'(flush_out), 32'd0);
    check("rd_exc_valid", 32'(exc_valid_out), 32'd0);
    check("rd_epc",       exc_epc_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_no_flush", 32'(flush_out), 32'd0);
      check("rd_idle",     32'(busy_out), 32'd0);
    end

    // EPC wraps below address 4.
    can_commit_in = 1'b1;
    set_head(1'b0, 5'd0, 32'h0, 4'd1, 1'b1, 32'h0000_0002);
    tick();
    check("wrap_epc",   exc_epc_out, 32'hffff_fffe);
    check("wrap_type",  32'(exc_type_out), 32'd1);
    check("wrap_count", retired_count_out, 32'd1);
    can_commit_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("wrap_idle", 32'(busy_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
